// File: rtl/fifo_occupancy_tracker.sv
// Occupancy counter for a scratchpad FIFO: multi-word push/pop per cycle,
// saturating or modulo-(DEPTH+1) overflow handling, thresholds, sticky errors and a high-water mark.
module fifo_occupancy_tracker #(
  parameter int DEPTH    = 8,
  parameter int CNT_W    = $clog2(DEPTH + 1),
  parameter int STEP_W   = 2,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  input  logic [STEP_W-1:0] inc_amt,
  input  logic              dec,
  input  logic [STEP_W-1:0] dec_amt,
  input  logic [CNT_W-1:0]  af_thresh,
  input  logic [CNT_W-1:0]  ae_thresh,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  peak,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  // Two guard bits over the wider operand keep count+step and count-step exact.
  localparam int SUM_W = ((CNT_W > STEP_W) ? CNT_W : STEP_W) + 2;
  localparam logic signed [SUM_W-1:0] DEPTH_S  = SUM_W'(DEPTH);
  localparam logic signed [SUM_W-1:0] MODULUS  = SUM_W'(DEPTH + 1);
  localparam logic [CNT_W-1:0]        DEPTH_C  = CNT_W'(DEPTH);

  logic signed [SUM_W-1:0] add_term;
  logic signed [SUM_W-1:0] sub_term;
  logic signed [SUM_W-1:0] count_ext;
  logic signed [SUM_W-1:0] sum;
  logic                    ovf_evt;
  logic                    udf_evt;
  logic [CNT_W-1:0]        count_nxt;
  logic [CNT_W-1:0]        peak_nxt;

  always_comb begin
    add_term  = inc ? signed'({{(SUM_W - STEP_W){1'b0}}, inc_amt}) : '0;
    sub_term  = dec ? signed'({{(SUM_W - STEP_W){1'b0}}, dec_amt}) : '0;
    count_ext = signed'({{(SUM_W - CNT_W){1'b0}}, count});
    sum       = count_ext + add_term - sub_term;
    ovf_evt   = (sum > DEPTH_S);
    udf_evt   = sum[SUM_W-1];
    count_nxt = CNT_W'(sum);
    if (ovf_evt) begin
      count_nxt = SATURATE ? DEPTH_C : CNT_W'(sum - MODULUS);
    end else if (udf_evt) begin
      count_nxt = SATURATE ? '0 : CNT_W'(sum + MODULUS);
    end
    peak_nxt = (count_nxt > peak) ? count_nxt : peak;
  end

  // State moves on the falling edge to line up with the FIFO pointer logic.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      peak      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (clear) begin
        count <= '0;
        peak  <= '0;
      end else begin
        count <= count_nxt;
        peak  <= peak_nxt;
      end
      // A fresh error on the err_clr edge wins; clear never raises an error.
      overflow  <= (overflow  & ~err_clr) | (ovf_evt & ~clear);
      underflow <= (underflow & ~err_clr) | (udf_evt & ~clear);
    end
  end

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= ae_thresh);
  assign almost_full  = (count >= af_thresh);

endmodule

// File: tb/tb_fifo_occupancy_tracker.sv
// Bench for fifo_occupancy_tracker: one wrapping and one saturating instance
// share stimulus and are checked against an integer reference model.
module tb_fifo_occupancy_tracker;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
  localparam int STEP_W = 2;

  logic clk = 1'b0;
  logic reset, clear, inc, dec, err_clr;
  logic [STEP_W-1:0] inc_amt, dec_amt;
  logic [CNT_W-1:0]  af_thresh, ae_thresh;

  // index 0: SATURATE=0, index 1: SATURATE=1
  logic [CNT_W-1:0] count_o [2];
  logic [CNT_W-1:0] peak_o  [2];
  logic empty_o [2];
  logic full_o  [2];
  logic ae_o    [2];
  logic af_o    [2];
  logic ovf_o   [2];
  logic udf_o   [2];

  int m_cnt [2];
  int m_peak[2];
  bit m_ovf [2];
  bit m_udf [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_occupancy_tracker #(.DEPTH(DEPTH), .STEP_W(STEP_W), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear), .inc(inc), .inc_amt(inc_amt),
    .dec(dec), .dec_amt(dec_amt), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .err_clr(err_clr), .count(count_o[0]), .peak(peak_o[0]), .empty(empty_o[0]),
    .full(full_o[0]), .almost_empty(ae_o[0]), .almost_full(af_o[0]),
    .overflow(ovf_o[0]), .underflow(udf_o[0]));

  fifo_occupancy_tracker #(.DEPTH(DEPTH), .STEP_W(STEP_W), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .inc(inc), .inc_amt(inc_amt),
    .dec(dec), .dec_amt(dec_amt), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .err_clr(err_clr), .count(count_o[1]), .peak(peak_o[1]), .empty(empty_o[1]),
    .full(full_o[1]), .almost_empty(ae_o[1]), .almost_full(af_o[1]),
    .overflow(ovf_o[1]), .underflow(udf_o[1]));

  // Reference model: plain integer occupancy with the overflow policy applied by mode.
  task automatic model_edge();
    int n, m;
    bit eo, eu;
    m = DEPTH + 1;
    for (int s = 0; s < 2; s++) begin
      n  = m_cnt[s] + (inc ? int'(inc_amt) : 0) - (dec ? int'(dec_amt) : 0);
      eo = 1'b0;
      eu = 1'b0;
      if (clear) begin
        m_cnt[s]  = 0;
        m_peak[s] = 0;
      end else begin
        if (n > DEPTH) begin
          eo = 1'b1;
          m_cnt[s] = (s == 1) ? DEPTH : n % m;
        end else if (n < 0) begin
          eu = 1'b1;
          m_cnt[s] = (s == 1) ? 0 : ((n % m) + m) % m;
        end else begin
          m_cnt[s] = n;
        end
        if (m_cnt[s] > m_peak[s]) m_peak[s] = m_cnt[s];
      end
      m_ovf[s] = (m_ovf[s] && !err_clr) || eo;
      m_udf[s] = (m_udf[s] && !err_clr) || eu;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0; m_peak[s] = 0; m_ovf[s] = 1'b0; m_udf[s] = 1'b0;
    end
  endtask

  task automatic step(input bit i, input int ia, input bit d, input int da,
                      input bit clr = 1'b0, input bit ec = 1'b0);
    @(posedge clk);
    inc = i; inc_amt = ia[STEP_W-1:0];
    dec = d; dec_amt = da[STEP_W-1:0];
    clear = clr; err_clr = ec;
    @(negedge clk);
    model_edge();
    #1;
    inc = 1'b0; dec = 1'b0; clear = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    reset = 1'b1;
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 0; inc = 0; dec = 0; err_clr = 0;
    inc_amt = '0; dec_amt = '0; af_thresh = '0; ae_thresh = '0;
    model_reset();
    #3;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (count_o[s] !== 4'd0 || peak_o[s] !== 4'd0 || empty_o[s] !== 1'b1 || full_o[s] !== 1'b0 ||
          ae_o[s] !== 1'b1 || af_o[s] !== 1'b1 || ovf_o[s] !== 1'b0 || udf_o[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: cnt=%0d pk=%0d e=%b f=%b ae=%b af=%b o=%b u=%b, want 0 0 1 0 1 1 0 0",
                 s, count_o[s], peak_o[s], empty_o[s], full_o[s], ae_o[s], af_o[s], ovf_o[s], udf_o[s]);
      end
    end
    @(posedge clk);
    reset = 1'b0;
    af_thresh = 4'd6; ae_thresh = 4'd2;
  endtask

  task automatic test_async_reset();
    step(1, 3, 0, 0);
    step(1, 2, 0, 0);
    n_checks++;
    if (count_o[1] !== 4'd5) begin
      n_fail++;
      $display("FAIL pre_reset_count: got %0d want 5", count_o[1]);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (count_o[s] !== 4'd0 || empty_o[s] !== 1'b1 || peak_o[s] !== 4'd0 ||
          ovf_o[s] !== 1'b0 || udf_o[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset[%0d]: cnt=%0d e=%b pk=%0d o=%b u=%b, want 0 1 0 0 0",
                 s, count_o[s], empty_o[s], peak_o[s], ovf_o[s], udf_o[s]);
      end
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_saturate_overflow();
    int exp_sat[3] = '{3, 6, 8};
    int exp_wrap[3] = '{3, 6, 0};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1, 3, 0, 0);
      n_checks++;
      if (count_o[1] !== CNT_W'(exp_sat[k]) || count_o[0] !== CNT_W'(exp_wrap[k])) begin
        n_fail++;
        $display("FAIL inc3_step%0d: sat=%0d wrap=%0d want %0d %0d",
                 k, count_o[1], count_o[0], exp_sat[k], exp_wrap[k]);
      end
    end
    n_checks++;
    if (full_o[1] !== 1'b1 || ovf_o[1] !== 1'b1 || peak_o[1] !== 4'd8 || ovf_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_full: full=%b ovf=%b peak=%0d wrap_ovf=%b want 1 1 8 1",
               full_o[1], ovf_o[1], peak_o[1], ovf_o[0]);
    end
  endtask

  task automatic test_net_underflow();
    do_reset();
    step(1, 2, 0, 0);
    step(1, 1, 1, 3);
    n_checks++;
    if (count_o[1] !== 4'd0 || udf_o[1] !== 1'b0 || count_o[0] !== 4'd0 || udf_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL net_zero: sat=%0d/%b wrap=%0d/%b want 0/0 0/0",
               count_o[1], udf_o[1], count_o[0], udf_o[0]);
    end
    step(0, 0, 1, 1);
    n_checks++;
    if (count_o[1] !== 4'd0 || udf_o[1] !== 1'b1 || count_o[0] !== 4'd8 || udf_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: sat=%0d/%b wrap=%0d/%b want 0/1 8/1",
               count_o[1], udf_o[1], count_o[0], udf_o[0]);
    end
  endtask

  task automatic test_thresholds();
    do_reset();
    af_thresh = 4'd6; ae_thresh = 4'd2;
    for (int k = 1; k <= 7; k++) begin
      step(1, 1, 0, 0);
      n_checks++;
      if (ae_o[1] !== (k <= 2) || af_o[1] !== (k >= 6) || count_o[1] !== CNT_W'(k)) begin
        n_fail++;
        $display("FAIL thresh_k%0d: cnt=%0d ae=%b af=%b want %0d %b %b",
                 k, count_o[1], ae_o[1], af_o[1], k, (k <= 2), (k >= 6));
      end
    end
    af_thresh = 4'd9; ae_thresh = 4'd12;
    #1;
    n_checks++;
    if (af_o[1] !== 1'b0 || ae_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL thresh_over_depth: af=%b ae=%b want 0 1", af_o[1], ae_o[1]);
    end
    af_thresh = 4'd6; ae_thresh = 4'd2;
  endtask

  task automatic test_wrap();
    do_reset();
    step(1, 3, 0, 0);
    step(1, 3, 0, 0);
    step(1, 1, 0, 0);
    step(1, 3, 0, 0);
    n_checks++;
    if (count_o[0] !== 4'd1 || ovf_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_over: cnt=%0d ovf=%b want 1 1", count_o[0], ovf_o[0]);
    end
    step(0, 0, 1, 2, 0, 1);
    n_checks++;
    if (count_o[0] !== 4'd8 || udf_o[0] !== 1'b1 || ovf_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_under_errclr: cnt=%0d udf=%b ovf=%b want 8 1 0",
               count_o[0], udf_o[0], ovf_o[0]);
    end
    n_checks++;
    if (count_o[1] !== 4'd6 || ovf_o[1] !== 1'b0 || udf_o[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_errclr: cnt=%0d ovf=%b udf=%b want 6 0 0",
               count_o[1], ovf_o[1], udf_o[1]);
    end
  endtask

  task automatic test_err_clr_and_clear();
    do_reset();
    repeat (3) step(1, 3, 0, 0);
    step(1, 3, 0, 0, 0, 1);
    n_checks++;
    if (ovf_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL set_beats_clr: ovf=%b want 1", ovf_o[1]);
    end
    step(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (ovf_o[1] !== 1'b0 || ovf_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clr: sat_ovf=%b wrap_ovf=%b want 0 0", ovf_o[1], ovf_o[0]);
    end
    step(1, 3, 0, 0, 1, 0);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (count_o[s] !== 4'd0 || peak_o[s] !== 4'd0 || ovf_o[s] !== 1'b0 || udf_o[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL clear[%0d]: cnt=%0d pk=%0d o=%b u=%b want 0 0 0 0",
                 s, count_o[s], peak_o[s], ovf_o[s], udf_o[s]);
      end
    end
  endtask

  task automatic test_random();
    int bad;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 15) == 0) begin
        af_thresh = CNT_W'($urandom_range(0, 10));
        ae_thresh = CNT_W'($urandom_range(0, 10));
      end
      step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0));
      for (int s = 0; s < 2; s++) begin
        bad = 0;
        if (count_o[s] !== CNT_W'(m_cnt[s]))                   bad++;
        if (peak_o[s]  !== CNT_W'(m_peak[s]))                  bad++;
        if (empty_o[s] !== (m_cnt[s] == 0))                    bad++;
        if (full_o[s]  !== (m_cnt[s] == DEPTH))                bad++;
        if (ae_o[s]    !== (m_cnt[s] <= int'(ae_thresh)))      bad++;
        if (af_o[s]    !== (m_cnt[s] >= int'(af_thresh)))      bad++;
        if (ovf_o[s]   !== m_ovf[s])                           bad++;
        if (udf_o[s]   !== m_udf[s])                           bad++;
        n_checks++;
        if (bad != 0) begin
          n_fail++;
          $display("FAIL random[%0d] t=%0d: cnt=%0d pk=%0d o=%b u=%b ae=%b af=%b, want cnt=%0d pk=%0d o=%b u=%b",
                   s, t, count_o[s], peak_o[s], ovf_o[s], udf_o[s], ae_o[s], af_o[s],
                   m_cnt[s], m_peak[s], m_ovf[s], m_udf[s]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_saturate_overflow();
    test_net_underflow();
    test_thresholds();
    test_wrap();
    test_err_clr_and_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_occupancy_tracker.md
Name: fifo_occupancy_tracker

Overview:
Parametrised occupancy counter for the PE scratchpad FIFOs. It generalises the single-step up/down counter to multi-word push/pop per cycle, a configurable capacity, and selectable saturate/wrap overflow handling. It also provides programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a high-water mark. It sits beside each sync FIFO and feeds the PE control FSM's stall/ready logic.

Parameters:
DEPTH, 8, FIFO capacity in words; count range 0..DEPTH.
CNT_W, $clog2(DEPTH+1), width of count, peak and threshold ports (derived; never overridden).
STEP_W, 2, width of inc_amt/dec_amt; per-cycle step 0..2^STEP_W-1.
SATURATE, 1, 1 = clamp at 0/DEPTH; 0 = wrap modulo DEPTH+1.

Ports:
clk  in  1  clock; all state updates on the falling edge, matching the FIFO pointer logic.
reset  in  1  asynchronous, active-high; clears all state.
clear  in  1  synchronous clear of count and peak; error flags are not affected.
inc  in  1  push request.
inc_amt  in  STEP_W  words pushed when inc=1.
dec  in  1  pop request.
dec_amt  in  STEP_W  words popped when dec=1.
af_thresh  in  CNT_W  almost-full threshold.
ae_thresh  in  CNT_W  almost-empty threshold.
err_clr  in  1  synchronous clear of the sticky error flags.
count  out  CNT_W  current occupancy.
peak  out  CNT_W  maximum count since reset/clear.
empty  out  1  count==0.
full  out  1  count==DEPTH.
almost_empty  out  1  count<=ae_thresh.
almost_full  out  1  count>=af_thresh.
overflow  out  1  sticky; set when a sum exceeds DEPTH.
underflow  out  1  sticky; set when a sum goes below 0.

Behaviour:
- Reset (async, any time, including mid-operation): count=0, peak=0, overflow=0, underflow=0, empty=1, full=0, almost_empty=1, almost_full=(af_thresh==0). Outputs take these values immediately, without waiting for an edge.
- Next-value computation at each falling edge, in signed CNT_W+2 arithmetic:
  - nxt = count + (inc ? inc_amt : 0) - (dec ? dec_amt : 0).
  - inc with inc_amt=0 is a no-op; likewise dec with dec_amt=0.
  - Simultaneous inc and dec net out in one edge. An error is judged only on the net result, never on intermediate values.
- Overflow, nxt>DEPTH:
  - SATURATE=1: count<=DEPTH.
  - SATURATE=0: count<=nxt-(DEPTH+1).
  - Both modes set overflow<=1.
- Underflow, nxt<0:
  - SATURATE=1: count<=0.
  - SATURATE=0: count<=nxt+(DEPTH+1).
  - Both modes set underflow<=1.
- Otherwise count<=nxt.
- Latency: count changes one falling edge after inc/dec are sampled. No combinational path from inc/dec to count.
- Status flags:
  - empty, full, almost_empty and almost_full are combinational from count and the threshold ports.
  - A threshold change takes effect immediately.
  - Thresholds greater than DEPTH are legal: almost_full then never asserts; almost_empty is then always 1.
- peak: on each edge, peak<=max(peak, new count).
- Priority, highest first: reset > clear > inc/dec update.
  - clear=1 forces count<=0 and peak<=0 and ignores inc/dec that edge.
  - clear=1 sets no error.
- Error flags:
  - err_clr=1 clears both flags at the edge.
  - If a new error occurs on the same edge as err_clr, the set wins and the flag stays 1.
  - Flags stay set until err_clr or reset.
- DEPTH not a power of two: the wrap modulus is DEPTH+1, never 2^CNT_W.

Test Plan:
1. DEPTH=8, SATURATE=1, count=5; pulse reset between edges -> count=0, empty=1, peak=0, errors=0 immediately, before the next edge.
2. From 0, inc_amt=3 on three edges -> count 3, 6, 8; full=1, overflow=1 on the third edge; peak=8.
3. count=2; inc=1/amt 1 with dec=1/amt 3 on one edge -> count=0, no underflow. Next edge dec amt 1 -> count=0, underflow=1.
4. af_thresh=6, ae_thresh=2; step count 1..7 -> almost_empty=1 for 1..2, then 0; almost_full=1 from 6 onward. Change af_thresh to 9 -> almost_full=0 immediately.
5. SATURATE=0, DEPTH=8: count=7, inc amt 3 -> count=1, overflow=1. Then err_clr plus dec amt 2 on one edge -> count=8, underflow=1, overflow=0.
6. overflow=1; err_clr with a new overflow on one edge -> overflow stays 1. err_clr alone -> 0. clear with inc amt 3 -> count=0, peak=0, no error.
